// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the FSM state encoding, default MUL/DIV opcodes and counter width.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } alu_seq_state_t;

   localparam logic [4:0] MUL_OPCODE_DEF = 5'b01111;
   localparam logic [4:0] DIV_OPCODE_DEF = 5'b10000;

   localparam int CNT_W = 4;

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for the shared ALU: request in, timed EXEC, Z pair out.
// Define ALU_SEQ_FLAGS_EN to add the registered rsp_zero/rsp_neg result flags.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter logic [4:0] MUL_OPCODE    = MUL_OPCODE_DEF,
   parameter logic [4:0] DIV_OPCODE    = DIV_OPCODE_DEF,
   parameter int         MULDIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_ra,
   input  logic [31:0] req_rb,
   output logic [31:0] alu_ra,
   output logic [31:0] alu_rb,
   output logic [4:0]  alu_opcode,
   input  logic [63:0] alu_rz,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_zhi,
   output logic [31:0] rsp_zlo,
   output logic        rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
   output logic        rsp_zero,
   output logic        rsp_neg,
`endif
   output logic        busy
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_EXEC = ST_EXEC;
   localparam logic [1:0] S_RESP = ST_RESP;

   localparam logic [CNT_W-1:0] MD_LEN = CNT_W'(MULDIV_CYCLES);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             dz;

   logic             is_md;
   logic             div0;
   logic [CNT_W-1:0] len;
   logic             last;

   assign is_md = (req_opcode == MUL_OPCODE) || (req_opcode == DIV_OPCODE);
   assign div0  = (req_opcode == DIV_OPCODE) && (req_rb == 32'd0);

   // Divide by zero is resolved in one EXEC cycle whatever the opcode length.
   assign len  = (is_md && !div0) ? MD_LEN : ONE;
   assign last = (cnt == ONE);

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         dz         <= 1'b0;
         alu_ra     <= '0;
         alu_rb     <= '0;
         alu_opcode <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_zhi    <= '0;
         rsp_zlo    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         rsp_zero   <= 1'b0;
         rsp_neg    <= 1'b0;
`endif
      end else begin
         unique case (1'b1)
            (state == S_IDLE): begin
               if (req_valid) begin
                  alu_ra     <= req_ra;
                  alu_rb     <= req_rb;
                  alu_opcode <= req_opcode;
                  dz         <= div0;
                  cnt        <= len;
                  state      <= S_EXEC;
               end
            end
            (state == S_EXEC): begin
               cnt <= cnt - ONE;
               if (last) begin
                  rsp_zhi   <= dz ? 32'd0 : alu_rz[63:32];
                  rsp_zlo   <= dz ? 32'd0 : alu_rz[31:0];
                  rsp_err   <= dz;
`ifdef ALU_SEQ_FLAGS_EN
                  rsp_zero  <= dz ? 1'b1 : (alu_rz == 64'd0);
                  rsp_neg   <= dz ? 1'b0 : alu_rz[63];
`endif
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            (state == S_RESP): begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU model.
// Build with ALU_SEQ_FLAGS_EN defined to also check rsp_zero/rsp_neg.
module tb_alu_op_sequencer;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;
   localparam logic [4:0] OP_RAW = 5'b00001;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_opcode;
   logic [31:0] req_ra;
   logic [31:0] req_rb;
   logic [31:0] alu_ra;
   logic [31:0] alu_rb;
   logic [4:0]  alu_opcode;
   logic [63:0] alu_rz;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_zhi;
   logic [31:0] rsp_zlo;
   logic        rsp_err;
   logic        busy;
`ifdef ALU_SEQ_FLAGS_EN
   logic        rsp_zero;
   logic        rsp_neg;
`endif

   alu_op_sequencer #(
      .MUL_OPCODE    (OP_MUL),
      .DIV_OPCODE    (OP_DIV),
      .MULDIV_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_ra     (req_ra),
      .req_rb     (req_rb),
      .alu_ra     (alu_ra),
      .alu_rb     (alu_rb),
      .alu_opcode (alu_opcode),
      .alu_rz     (alu_rz),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_zhi    (rsp_zhi),
      .rsp_zlo    (rsp_zlo),
      .rsp_err    (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
      .rsp_zero   (rsp_zero),
      .rsp_neg    (rsp_neg),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: sign-extended add/sub, signed mul, {rem,quot} div.
   logic [63:0] sa, sb;
   logic [31:0] quo, rem;
   always_comb begin
      sa     = {{32{alu_ra[31]}}, alu_ra};
      sb     = {{32{alu_rb[31]}}, alu_rb};
      quo    = 32'd0;
      rem    = 32'd0;
      alu_rz = {alu_ra, alu_rb};
      case (alu_opcode)
         OP_ADD: alu_rz = sa + sb;
         OP_SUB: alu_rz = sa - sb;
         OP_MUL: alu_rz = sa * sb;
         OP_DIV: begin
            if (alu_rb == 32'd0) begin
               alu_rz = 64'hDEADBEEF_CAFEF00D;
            end else begin
               quo    = $signed(alu_ra) / $signed(alu_rb);
               rem    = $signed(alu_ra) % $signed(alu_rb);
               alu_rz = {rem, quo};
            end
         end
         default: alu_rz = {alu_ra, alu_rb};
      endcase
   end

   typedef struct {
      logic [31:0] zhi;
      logic [31:0] zlo;
      logic        err;
      logic        zero;
      logic        neg;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] zhi,
                               input logic [31:0] zlo,
                               input logic err, input int lat);
      exp_t e;
      e.zhi  = zhi;
      e.zlo  = zlo;
      e.err  = err;
      e.zero = ({zhi, zlo} == 64'd0);
      e.neg  = zhi[31];
      e.lat  = lat;
      e.acc  = 0;
      return e;
   endfunction

   // Monitor: compares every cycle a response is presented.
   initial begin : monitor
      bit pv;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (reset || !rsp_valid) begin
            pv = 1'b0;
         end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got zhi=%h zlo=%h expected none",
                     rsp_zhi, rsp_zlo);
            pv = 1'b1;
         end else begin
            if (!pv)
               check("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
            check("zhi", 64'(rsp_zhi), 64'(sb_q[0].zhi));
            check("zlo", 64'(rsp_zlo), 64'(sb_q[0].zlo));
            check("err", 64'(rsp_err), 64'(sb_q[0].err));
`ifdef ALU_SEQ_FLAGS_EN
            check("zero", 64'(rsp_zero), 64'(sb_q[0].zero));
            check("neg", 64'(rsp_neg), 64'(sb_q[0].neg));
`endif
            check("req_ready_in_resp", 64'(req_ready), 64'd0);
            if (rsp_ready) void'(sb_q.pop_front());
            pv = 1'b1;
         end
      end
   end

   task automatic present(input logic [4:0] op, input logic [31:0] ra,
                          input logic [31:0] rb);
      req_opcode = op;
      req_ra     = ra;
      req_rb     = rb;
      req_valid  = 1'b1;
   endtask

   // Returns at posedge+1 just after the accepting edge.
   task automatic accept(input exp_t e, input bit push);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 60) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
            req_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.acc = cyc;
      if (push) sb_q.push_back(e);
   endtask

   task automatic send(input logic [4:0] op, input logic [31:0] ra,
                       input logic [31:0] rb, input exp_t e);
      present(op, ra, rb);
      accept(e, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_alu_ra"}, 64'(alu_ra), 64'd0);
      check({tag, "_alu_rb"}, 64'(alu_rb), 64'd0);
      check({tag, "_alu_op"}, 64'(alu_opcode), 64'd0);
      check({tag, "_zhi"}, 64'(rsp_zhi), 64'd0);
      check({tag, "_zlo"}, 64'(rsp_zlo), 64'd0);
      check({tag, "_err"}, 64'(rsp_err), 64'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check({tag, "_zero"}, 64'(rsp_zero), 64'd0);
      check({tag, "_neg"}, 64'(rsp_neg), 64'd0);
`endif
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_opcode = '0;
      req_ra     = '0;
      req_rb     = '0;
      rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("rst");
      @(posedge clk);
      #1;

      send(OP_ADD, 32'd8, 32'd8, mk(32'd0, 32'd16, 1'b0, 1));

      // MUL: busy through 4 EXEC cycles and 1 RESP cycle.
      send(OP_MUL, 32'hFFFFFFF8, 32'hFFFFFFF8, mk(32'd0, 32'd64, 1'b0, 4));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("mul_busy", 64'(busy), 64'd1);
         check("mul_alu_ra", 64'(alu_ra), 64'hFFFFFFF8);
      end
      @(negedge clk);
      check("mul_idle", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      send(OP_MUL, 32'h10000, 32'h10000, mk(32'd1, 32'd0, 1'b0, 4));
      send(OP_MUL, 32'hFFFFFFFD, 32'd5,
           mk(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 4));
      send(OP_DIV, 32'd36, 32'd6, mk(32'd0, 32'd6, 1'b0, 4));
      send(OP_DIV, 32'd36, 32'd0, mk(32'd0, 32'd0, 1'b1, 1));
      send(OP_ADD, 32'hFFFFFFFF, 32'd1, mk(32'd0, 32'd0, 1'b0, 1));
      send(OP_SUB, 32'd8, 32'd8, mk(32'd0, 32'd0, 1'b0, 1));
      send(OP_SUB, 32'd8, 32'd16, mk(32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0, 1));
      send(OP_RAW, 32'h12345678, 32'h9ABCDEF0,
           mk(32'h12345678, 32'h9ABCDEF0, 1'b0, 1));
      drain();

      // Backpressure: result held, second request ignored until handshake.
      rsp_ready = 1'b0;
      send(OP_SUB, 32'd16, 32'd8, mk(32'd0, 32'd8, 1'b0, 1));
      present(OP_ADD, 32'd5, 32'd7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_alu_ra", 64'(alu_ra), 64'd16);
      end
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      accept(mk(32'd0, 32'd12, 1'b0, 1), 1'b1);
      drain();

      // Reset in the 2nd EXEC cycle of a MUL discards it.
      present(OP_MUL, 32'd7, 32'd9);
      accept(mk(32'd0, 32'd63, 1'b0, 4), 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      repeat (8) @(posedge clk);
      #1;

      send(OP_ADD, 32'd1, 32'd2, mk(32'd0, 32'd3, 1'b0, 1));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
